// File: rtl/key_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One pushbutton: 2-flop synchronizer, debounce FSM, auto-repeat timer.
//   state       | meaning
//   RELEASED    | key accepted as up, waiting for a raw press
//   DEB_PRESS   | raw press seen, counting stable cycles
//   PRESSED     | key accepted as held, repeat timer running
//   DEB_RELEASE | raw release seen, counting stable cycles
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic repeat_pulse_o
);

  localparam int unsigned DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = cnt_width(RPT_MAX);
  localparam logic [DW-1:0] DEB_LIM = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE = DW'(1);
  localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] RPT_ONE = RW'(1);
  localparam bit            RPT_EN  = (REPEAT_DELAY != 0);

  logic          sync1_q, sync2_q;
  key_state_t    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      rpt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= ~key_n_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = DEB_PRESS;
          cnt_d   = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!sync2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LIM) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          rpt_d     = RPT_DLY;
          press_d   = 1'b1;
          pressed_d = 1'b1;
        end else if (cnt_q < DEB_LIM) begin
          cnt_d = cnt_q + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = DEB_RELEASE;
          cnt_d   = DEB_ONE;
        end else if (RPT_EN) begin
          // Timer only advances on cycles that stay held; bounces freeze it.
          if (rpt_q == RPT_ONE) begin
            repeat_d = 1'b1;
            rpt_d    = RPT_PER;
          end else if (rpt_q != '0) begin
            rpt_d = rpt_q - RPT_ONE;
          end
        end
      end
      DEB_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LIM) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          rpt_d     = '0;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else if (cnt_q < DEB_LIM) begin
          cnt_d = cnt_q + DEB_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign repeat_pulse_o  = repeat_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low board pushbuttons into clean levels and
// single-cycle press/release/auto-repeat pulses, one channel per key.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_i          (CLOCK_50),
      .rst_i          (reset),
      .key_n_i        (KEY[i]),
      .pressed_o      (pressed[i]),
      .press_pulse_o  (press_pulse[i]),
      .release_pulse_o(release_pulse[i]),
      .repeat_pulse_o (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench: every cycle compares all outputs against a window-based
// reference model, plus directed latency/repeat scenarios and random bouncing.
module tb_key_debouncer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] KEY = '1;
  logic [N-1:0] pressed, press_pulse, release_pulse, repeat_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  key_debouncer #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(KEY), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a key's accepted level flips once the synchronized
  // level has disagreed with it for D+1 consecutive edges. Repeats fire when
  // the count of uninterrupted held edges since the press hits RD + k*RP.
  bit           hist[N][$];
  bit           lvl[N];
  int           held[N];
  int           e = 0;
  logic [N-1:0] exp_lvl = '0, exp_prs = '0, exp_rel = '0, exp_rpt = '0;

  function automatic bit vis(int k, int t);
    int idx = t - 2;
    if (idx < 0 || idx >= hist[k].size()) return 1'b0;
    return hist[k][idx];
  endfunction

  task automatic tick();
    bit flip;
    @(posedge clk);
    cyc++;
    exp_prs = '0; exp_rel = '0; exp_rpt = '0;
    if (reset) begin
      e = 0;
      for (int k = 0; k < N; k++) begin
        hist[k].delete();
        lvl[k]  = 1'b0;
        held[k] = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        hist[k].push_back(~KEY[k]);
        flip = 1'b1;
        for (int j = 0; j <= D; j++)
          if (vis(k, e - j) == lvl[k]) flip = 1'b0;
        if (flip) begin
          lvl[k] = ~lvl[k];
          if (lvl[k]) exp_prs[k] = 1'b1; else exp_rel[k] = 1'b1;
          held[k] = 0;
        end else if (lvl[k] && vis(k, e - 1) && vis(k, e)) begin
          held[k]++;
          if (held[k] >= RD && ((held[k] - RD) % RP) == 0) exp_rpt[k] = 1'b1;
        end
      end
      e++;
    end
    for (int k = 0; k < N; k++) exp_lvl[k] = lvl[k];
    #1;
    check_eq("pressed", int'(pressed), int'(exp_lvl));
    check_eq("press_pulse", int'(press_pulse), int'(exp_prs));
    check_eq("release_pulse", int'(release_pulse), int'(exp_rel));
    check_eq("repeat_pulse", int'(repeat_pulse), int'(exp_rpt));
  endtask

  // Edges from the first edge sampling the new level until the pulse (edge 0 = first).
  task automatic wait_pulse(input int k, input bit rel, output int n);
    n = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if ((rel ? release_pulse[k] : press_pulse[k]) === 1'b1) return;
    end
    n = 999;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int lat;
  int rpt_q[$];
  int cnt;

  initial begin
    bit tgt[N];
    int left[N];
    bit bnc;

    idle(3);
    check_eq("reset_pressed", int'(pressed), 0);
    check_eq("reset_pulses", int'(press_pulse | release_pulse | repeat_pulse), 0);
    reset = 1'b0;
    idle(3);

    // Clean press
    KEY[0] = 1'b0;
    wait_pulse(0, 1'b0, lat);
    check_eq("clean_lat", lat, 6);
    check_eq("clean_vec", int'(press_pulse), 1);
    tick();
    check_eq("clean_one_cycle", int'(press_pulse[0]), 0);
    KEY = '1;
    idle(20);

    // Bounce: low 3, high 1, then steady low
    KEY[0] = 1'b0; idle(3);
    KEY[0] = 1'b1; idle(1);
    KEY[0] = 1'b0;
    wait_pulse(0, 1'b0, lat);
    check_eq("bounce_lat", lat, 6);
    KEY = '1;
    idle(20);

    // Glitch shorter than the debounce window
    cnt = 0;
    KEY[1] = 1'b0; idle(3);
    KEY[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (press_pulse[1] || pressed[1]) cnt++;
    end
    check_eq("glitch_none", cnt, 0);

    // Hold with auto-repeat, then release
    KEY[2] = 1'b0;
    wait_pulse(2, 1'b0, lat);
    check_eq("hold_lat", lat, 6);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (repeat_pulse[2]) rpt_q.push_back(i);
    end
    check_eq("rpt_count", rpt_q.size(), 4);
    if (rpt_q.size() >= 2) begin
      check_eq("rpt_first", rpt_q[0], RD);
      check_eq("rpt_second", rpt_q[1], RD + RP);
    end
    KEY[2] = 1'b1;
    wait_pulse(2, 1'b1, lat);
    check_eq("release_lat", lat, 6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (repeat_pulse[2]) cnt++;
    end
    check_eq("no_rpt_after_rel", cnt, 0);

    // Simultaneous presses
    KEY[0] = 1'b0; KEY[3] = 1'b0;
    wait_pulse(0, 1'b0, lat);
    check_eq("simul_vec", int'(press_pulse), 4'b1001);
    KEY = '1;
    idle(20);

    // Reset during DEB_PRESS with the key still held
    KEY[1] = 1'b0;
    idle(4);
    reset = 1'b1;
    idle(2);
    check_eq("rst_mid_out", int'(pressed | press_pulse | release_pulse | repeat_pulse), 0);
    reset = 1'b0;
    wait_pulse(1, 1'b0, lat);
    check_eq("rst_mid_lat", lat, 6);
    KEY = '1;
    idle(20);

    // Random bouncing keys with occasional resets
    for (int k = 0; k < N; k++) begin
      tgt[k]  = 1'b0;
      left[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (left[k] == 0) begin
          tgt[k]  = 1'($urandom_range(0, 1));
          left[k] = $urandom_range(1, 30);
        end
        left[k]--;
        bnc    = ($urandom_range(0, 7) == 0);
        KEY[k] = ~(tgt[k] ^ bnc);
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    KEY = '1;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
